// File: rtl/hash_share_arbiter_pkg.sv
// Shared FSM encoding, requester indices and round-robin index helper for the hash share arbiter.
package hash_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  localparam int KDF_REQ = 0;
  localparam int MAC_REQ = 1;

  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/hash_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
// Zero latency; gnt_vld_o low when no request is pending.
module rr_arbiter
  import hash_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      ptr_i,
  output logic               gnt_vld_o,
  output logic [GW-1:0]      gnt_idx_o
);

  // Walk offsets from farthest to nearest so the nearest hit to ptr_i wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[rr_idx(int'(ptr_i), i, NUM_REQ)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = GW'(rr_idx(int'(ptr_i), i, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/hash_share_arbiter.sv
// Shares one hash engine between requesters round-robin; req_go to eng_go is 2 cycles.
// Grants only while eng_ready; holds the grant in RELEASE until the winner drops req_go.
module hash_share_arbiter
  import hash_share_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter int  IN_W    = 80,
  parameter int  OUT_W   = 512,
  parameter int  TIMEOUT = 4096,
  localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_go,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_err,
  output logic [OUT_W-1:0]        req_hash,
  input  logic                    eng_ready,
  output logic                    eng_go,
  output logic [IN_W-1:0]         eng_data,
  input  logic                    eng_done,
  input  logic [OUT_W-1:0]        eng_hash,
  output logic [GW-1:0]           grant_id,
  output logic                    busy
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  arb_state_e          state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [IN_W-1:0]     data_q, data_d;
  logic                go_q, go_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [OUT_W-1:0]    hash_q, hash_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                drop_q, drop_d;

  logic                pick_vld;
  logic [GW-1:0]       pick_idx;
  logic                req_held;
  logic                timeout_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr_arbiter (
    .req_i     (req_go),
    .ptr_i     (ptr_q),
    .gnt_vld_o (pick_vld),
    .gnt_idx_o (pick_idx)
  );

  assign req_held    = req_go[grant_q];
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    go_d    = go_q;
    done_d  = '0;
    err_d   = '0;
    hash_d  = hash_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && eng_ready) begin
          grant_d = pick_idx;
          data_d  = req_data[int'(pick_idx)*IN_W +: IN_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        go_d    = 1'b1;
        cnt_d   = '0;
        drop_d  = 1'b0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (!req_held) drop_d = 1'b1;
        // A done coinciding with the watchdog expiry still counts as success.
        if (eng_done) begin
          go_d    = 1'b0;
          hash_d  = eng_hash;
          state_d = ST_RELEASE;
          if (req_held && !drop_q) done_d[grant_q] = 1'b1;
        end else if (timeout_hit) begin
          go_d           = 1'b0;
          err_d[grant_q] = 1'b1;
          state_d        = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!req_held) begin
          ptr_d   = GW'(rr_idx(int'(grant_q), 1, NUM_REQ));
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      go_q    <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      hash_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      go_q    <= go_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hash_q  <= hash_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign req_done = done_q;
  assign req_err  = err_q;
  assign req_hash = hash_q;
  assign eng_go   = go_q;
  assign eng_data = data_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hash_share_arbiter.sv
// Bench for hash_share_arbiter: cycle vector table, directed corner sequences,
// then random requesters/engine checked against a transaction-level round-robin model.
module tb_hash_share_arbiter;

  localparam int N     = 2;
  localparam int IN_W  = 80;
  localparam int OUT_W = 512;
  localparam int TO    = 16;
  localparam int GW    = $clog2(N);

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_go;
  logic [N*IN_W-1:0]    req_data;
  logic [N-1:0]         req_done;
  logic [N-1:0]         req_err;
  logic [OUT_W-1:0]     req_hash;
  logic                 eng_ready;
  logic                 eng_go;
  logic [IN_W-1:0]      eng_data;
  logic                 eng_done;
  logic [OUT_W-1:0]     eng_hash;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  hash_share_arbiter #(.NUM_REQ(N), .IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_go(req_go), .req_data(req_data),
    .req_done(req_done), .req_err(req_err), .req_hash(req_hash),
    .eng_ready(eng_ready), .eng_go(eng_go), .eng_data(eng_data),
    .eng_done(eng_done), .eng_hash(eng_hash), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] rand_hash();
    logic [OUT_W-1:0] h;
    for (int k = 0; k < OUT_W / 32; k++) h[k*32 +: 32] = $urandom();
    return h;
  endfunction

  // Engine has been started (sample shows ISSUE); finish after lat busy cycles.
  task automatic run_job(input int lat, input logic [OUT_W-1:0] h);
    step();
    for (int k = 1; k < lat; k++) step();
    eng_hash = h;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  rg;
    logic        rdy;
    logic        ed;
    logic [15:0] hin;
    logic        eb;
    logic        eg;
    logic [1:0]  edn;
    logic [1:0]  eer;
    logic [0:0]  egn;
    logic [15:0] eh;
    logic [15:0] edat;
  } vec_t;

  vec_t tv[$];

  function automatic void addv(input logic [1:0] rg, input logic rdy, input logic ed,
                               input logic [15:0] hin, input logic eb, input logic eg,
                               input logic [1:0] edn, input logic [1:0] eer,
                               input logic [0:0] egn, input logic [15:0] eh,
                               input logic [15:0] edat);
    vec_t v;
    v.rg = rg; v.rdy = rdy; v.ed = ed; v.hin = hin; v.eb = eb; v.eg = eg;
    v.edn = edn; v.eer = eer; v.egn = egn; v.eh = eh; v.edat = edat;
    tv.push_back(v);
  endfunction

  // Random-phase model state
  int               mptr;
  bit               pend[N];
  int               holdc[N];
  logic [IN_W-1:0]  rdat[N];
  logic [N-1:0]     drv_go;
  logic [OUT_W-1:0] exp_hash;
  logic [OUT_W-1:0] hnext;
  logic [N-1:0]     oh;
  bit               exp_busy, g_pred, go_pred, job_on, rel_wait, rel_exit, found, drv_rdy, drv_done;
  int               pw, win, ecnt, elat, pulse_exp, dropped;

  initial begin
    rst = 1'b1; req_go = '0; req_data = '0; eng_ready = 1'b0; eng_done = 1'b0; eng_hash = '0;
    step();
    step();
    chk("reset_state", 640'({busy, eng_go, req_done, req_err, grant_id, req_hash, eng_data}), 640'(0));
    rst = 1'b0;

    // Single job with hold, spurious done in IDLE/RELEASE, then not-ready grant delay.
    addv(2'b00, 1, 1, 16'h11, 0, 0, 2'b00, 2'b00, 1'b0, 16'h00, 16'h0000);
    addv(2'b01, 1, 0, 16'h11, 1, 0, 2'b00, 2'b00, 1'b0, 16'h00, 16'h0123);
    addv(2'b01, 1, 0, 16'h11, 1, 1, 2'b00, 2'b00, 1'b0, 16'h00, 16'h0123);
    for (int k = 3; k <= 11; k++)
      addv(2'b01, 1, 0, 16'h11, 1, 1, 2'b00, 2'b00, 1'b0, 16'h00, 16'h0123);
    addv(2'b01, 1, 1, 16'hAB, 1, 0, 2'b01, 2'b00, 1'b0, 16'hAB, 16'h0123);
    addv(2'b01, 1, 0, 16'h22, 1, 0, 2'b00, 2'b00, 1'b0, 16'hAB, 16'h0123);
    addv(2'b01, 1, 1, 16'h33, 1, 0, 2'b00, 2'b00, 1'b0, 16'hAB, 16'h0123);
    for (int k = 15; k <= 17; k++)
      addv(2'b01, 1, 0, 16'h44, 1, 0, 2'b00, 2'b00, 1'b0, 16'hAB, 16'h0123);
    addv(2'b00, 1, 0, 16'h44, 0, 0, 2'b00, 2'b00, 1'b0, 16'hAB, 16'h0123);
    addv(2'b10, 0, 0, 16'h44, 0, 0, 2'b00, 2'b00, 1'b0, 16'hAB, 16'h0123);
    addv(2'b10, 0, 0, 16'h44, 0, 0, 2'b00, 2'b00, 1'b0, 16'hAB, 16'h0123);
    addv(2'b10, 1, 0, 16'h44, 1, 0, 2'b00, 2'b00, 1'b1, 16'hAB, 16'h0456);
    addv(2'b10, 1, 0, 16'h44, 1, 1, 2'b00, 2'b00, 1'b1, 16'hAB, 16'h0456);
    addv(2'b10, 1, 1, 16'hCD, 1, 0, 2'b10, 2'b00, 1'b1, 16'hCD, 16'h0456);
    addv(2'b00, 1, 0, 16'h55, 0, 0, 2'b00, 2'b00, 1'b1, 16'hCD, 16'h0456);

    for (int i = 0; i < tv.size(); i++) begin
      req_go    = tv[i].rg;
      req_data  = {IN_W'(16'h0456), IN_W'(16'h0123)};
      eng_ready = tv[i].rdy;
      eng_done  = tv[i].ed;
      eng_hash  = OUT_W'(tv[i].hin);
      step();
      chk($sformatf("vec%0d", i),
          640'({busy, eng_go, req_done, req_err, grant_id, req_hash, eng_data}),
          640'({tv[i].eb, tv[i].eg, tv[i].edn, tv[i].eer, tv[i].egn,
                OUT_W'(tv[i].eh), IN_W'(tv[i].edat)}));
    end
    eng_done = 1'b0;

    // Contention: both request, 0 first, 1 after 0 drops.
    req_go = 2'b11; step();
    chk("cont_first", 640'({busy, grant_id}), 640'({1'b1, 1'b0}));
    run_job(3, OUT_W'(512'h61));
    chk("cont_done0", 640'(req_done), 640'(2'b01));
    req_go = 2'b10; step();
    chk("cont_idle", 640'(busy), 640'(0));
    step();
    chk("cont_second", 640'({busy, grant_id}), 640'({1'b1, 1'b1}));
    run_job(2, OUT_W'(512'h62));
    chk("cont_done1", 640'(req_done), 640'(2'b10));
    req_go = 2'b00; step();
    req_go = 2'b01; step();
    run_job(1, OUT_W'(512'h63));
    req_go = 2'b00; step();
    // Pointer now past requester 0: a new 11 burst goes to 1 first.
    req_go = 2'b11; step();
    chk("burst2_first", 640'({busy, grant_id}), 640'({1'b1, 1'b1}));
    run_job(2, OUT_W'(512'h64));
    req_go = 2'b01; step(); step();
    chk("burst2_second", 640'({busy, grant_id}), 640'({1'b1, 1'b0}));
    run_job(2, OUT_W'(512'h65));
    req_go = 2'b00; step();

    // Watchdog: engine never answers.
    req_go = 2'b01; step(); step();
    for (int k = 1; k < TO; k++) step();
    chk("to_still_busy", 640'({eng_go, req_err}), 640'({1'b1, 2'b00}));
    step();
    chk("to_err", 640'({eng_go, req_done, req_err, req_hash}), 640'({1'b0, 2'b00, 2'b01, OUT_W'(512'h65)}));
    req_go = 2'b00; step();

    // Done on the watchdog's final cycle wins over timeout.
    req_go = 2'b01; step();
    run_job(TO, OUT_W'(512'h77));
    chk("to_edge_done", 640'({req_done, req_err, req_hash}), 640'({2'b01, 2'b00, OUT_W'(512'h77)}));
    req_go = 2'b00; step();

    // Requester abandons mid-job: hash still updates, no done, quick release.
    req_go = 2'b01; step(); step();
    req_go = 2'b00; step(); step();
    chk("drop_busy", 640'(eng_go), 640'(1));
    eng_hash = OUT_W'(512'h99); eng_done = 1'b1; step(); eng_done = 1'b0;
    chk("drop_nodone", 640'({busy, req_done, req_err, req_hash}), 640'({1'b1, 2'b00, 2'b00, OUT_W'(512'h99)}));
    step();
    chk("drop_release", 640'(busy), 640'(0));

    // Reset mid-job, then pointer must restart at 0.
    req_go = 2'b10; step(); step(); step();
    rst = 1'b1; step();
    chk("rst_busy", 640'({busy, eng_go, req_done, req_err, grant_id, req_hash, eng_data}), 640'(0));
    rst = 1'b0; req_go = 2'b11; step();
    chk("rst_ptr", 640'({busy, grant_id}), 640'({1'b1, 1'b0}));
    rst = 1'b1; req_go = 2'b00; step(); step();
    rst = 1'b0;

    // Random phase.
    mptr = 0; exp_hash = '0; exp_busy = 0; g_pred = 0; go_pred = 0; job_on = 0;
    rel_wait = 0; rel_exit = 0; pulse_exp = 0; win = 0; pw = 0; ecnt = 0; elat = 1;
    drv_go = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; holdc[i] = 0; rdat[i] = '0; end
    for (int it = 0; it < 4000; it++) begin
      step();
      oh = N'(1 << win);
      if (rel_exit) begin
        exp_busy = 0; rel_exit = 0; mptr = (win + 1) % N;
      end
      if (g_pred) begin
        chk("rnd_grant", 640'({busy, grant_id, eng_go, eng_data}), 640'({1'b1, GW'(pw), 1'b0, rdat[pw]}));
        g_pred = 0; go_pred = 1; exp_busy = 1; win = pw;
      end else if (go_pred) begin
        chk("rnd_go", 640'({eng_go, eng_data}), 640'({1'b1, rdat[win]}));
        go_pred = 0; job_on = 1; ecnt = 0; elat = $urandom_range(1, TO + 8);
      end
      if (pulse_exp == 1) begin
        chk("rnd_done", 640'({req_done, req_err, eng_go}), 640'({oh, 2'b00, 1'b0}));
      end else if (pulse_exp == 2) begin
        chk("rnd_err", 640'({req_done, req_err, eng_go}), 640'({2'b00, oh, 1'b0}));
      end else begin
        chk("rnd_nopulse", 640'({req_done, req_err}), 640'(0));
      end
      if (pulse_exp != 0) begin
        pulse_exp = 0; job_on = 0; rel_wait = 1; holdc[win] = $urandom_range(0, 3);
      end
      chk("rnd_busy", 640'(busy), 640'(exp_busy));
      chk("rnd_hash", 640'(req_hash), 640'(exp_hash));

      hnext = rand_hash();
      drv_done = 0;
      if (job_on) begin
        ecnt++;
        if (ecnt == elat) begin
          drv_done = 1; exp_hash = hnext; pulse_exp = 1;
        end else if (ecnt == TO) begin
          pulse_exp = 2;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        drv_done = 1;
      end
      dropped = -1;
      if (rel_wait) begin
        if (holdc[win] == 0) begin
          drv_go[win] = 1'b0; pend[win] = 0; rel_wait = 0; rel_exit = 1; dropped = win;
        end else begin
          holdc[win]--;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && i != dropped && $urandom_range(0, 3) == 0) begin
          rdat[i] = IN_W'({$urandom(), $urandom(), $urandom()});
          pend[i] = 1; drv_go[i] = 1'b1;
        end
      end
      drv_rdy = ($urandom_range(0, 3) != 0);
      if (!exp_busy && drv_go != '0 && drv_rdy) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && drv_go[(mptr + k) % N]) begin
            pw = (mptr + k) % N; found = 1;
          end
        end
        g_pred = 1;
      end
      req_go    = drv_go;
      for (int i = 0; i < N; i++) req_data[i*IN_W +: IN_W] = rdat[i];
      eng_ready = drv_rdy;
      eng_done  = drv_done;
      eng_hash  = hnext;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
